decrypt_iterative: RTL

DECRYPT_ITERATIVE -- requirements
Module: decrypt_iterative

---
 rtl/aes_pkg.sv | 64 ++++++
 rtl/aes_inv_round.sv | 45 ++++
 rtl/decrypt_iterative.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: types, legal key-size constants, Rcon table and GF(2^8) helpers.
// The S-boxes are computed from the field inverse instead of being tabulated.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  localparam int unsigned Aes128N  = 128;
  localparam int unsigned Aes128Nr = 10;
  localparam int unsigned Aes128Nk = 4;
  localparam int unsigned Aes192N  = 192;
  localparam int unsigned Aes192Nr = 12;
  localparam int unsigned Aes192Nk = 6;
  localparam int unsigned Aes256N  = 256;
  localparam int unsigned Aes256Nr = 14;
  localparam int unsigned Aes256Nk = 8;

  localparam byte_t Rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t acc = 8'h00;
    byte_t p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic byte_t gf_inv(byte_t a);
    byte_t p = a;
    byte_t r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic byte_t sbox(byte_t x);
    byte_t v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic byte_t inv_sbox(byte_t y);
    return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic word_t sub_word(word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last_i is set, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  state_t state_i,
  input  state_t round_key_i,
  input  logic   last_i,
  output state_t state_o
);

  function automatic word_t inv_mix_col(word_t col);
    byte_t a0 = col[31:24];
    byte_t a1 = col[23:16];
    byte_t a2 = col[15:8];
    byte_t a3 = col[7:0];
    return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
            gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
            gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
            gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
  endfunction

  state_t ark;

  // Byte k sits at [127-8k -: 8], row k%4, column k/4; row r rotates right by r.
  always_comb begin
    ark = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127-8*(4*c+r) -: 8] = inv_sbox(state_i[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    ark = ark ^ round_key_i;
  end

  always_comb begin
    state_o = ark;
    if (!last_i) begin
      for (int c = 0; c < 4; c++) begin
        state_o[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
      end
    end
  end

endmodule

// File: rtl/decrypt_iterative.sv
// Iterative AES inverse cipher: expands the whole key schedule one word per cycle,
// then performs one inverse round per cycle.
module decrypt_iterative
  import aes_pkg::*;
#(
  parameter int unsigned N  = 128,
  parameter int unsigned Nr = 10,
  parameter int unsigned Nk = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [N-1:0] key,
  output logic [127:0] out,
  output logic         done,
  output logic         busy
);

  localparam int unsigned NumWords = 4 * (Nr + 1);
  localparam int unsigned IdxW     = $clog2(NumWords + 1);
  localparam int unsigned RndW     = $clog2(Nr + 1);
  localparam int unsigned KmodW    = $clog2(Nk);

  typedef logic [IdxW-1:0] idx_t;
  localparam idx_t LastIdx = idx_t'(NumWords - 1);

  typedef enum logic [1:0] {StIdle, StExpand, StArk0, StRound} fsm_e;

  fsm_e             fsm_q, fsm_d;
  idx_t             idx_q, idx_d;
  logic [RndW-1:0]  rnd_q, rnd_d;
  logic [KmodW-1:0] kmod_q, kmod_d;
  logic [3:0]       rcon_idx_q, rcon_idx_d;
  state_t           out_q, out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             load, wr_word;

  word_t            w_q [NumWords];
  state_t           blk_q;
  state_t           round_key, round_out;
  word_t            prev_word, back_word, temp_word, new_word;
  logic [RndW-1:0]  rk_sel;
  idx_t             rk_base;

  always_comb begin
    prev_word = w_q[idx_q - idx_t'(1)];
    back_word = w_q[idx_q - idx_t'(Nk)];
    temp_word = prev_word;
    if (kmod_q == '0) begin
      temp_word = sub_word(rot_word(prev_word)) ^ {Rcon[rcon_idx_q], 24'h000000};
    end else if (Nk == 8 && kmod_q == KmodW'(4)) begin
      temp_word = sub_word(prev_word);
    end
    new_word = back_word ^ temp_word;
  end

  always_comb begin
    rk_sel    = (fsm_q == StArk0) ? RndW'(Nr) : rnd_q;
    rk_base   = idx_t'({rk_sel, 2'b00});
    round_key = {w_q[rk_base], w_q[rk_base + idx_t'(1)],
                 w_q[rk_base + idx_t'(2)], w_q[rk_base + idx_t'(3)]};
  end

  aes_inv_round u_inv_round (
    .state_i     (blk_q),
    .round_key_i (round_key),
    .last_i      (rnd_q == '0),
    .state_o     (round_out)
  );

  always_comb begin
    fsm_d      = fsm_q;
    idx_d      = idx_q;
    rnd_d      = rnd_q;
    kmod_d     = kmod_q;
    rcon_idx_d = rcon_idx_q;
    out_d      = out_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    load       = 1'b0;
    wr_word    = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (start) begin
          load       = 1'b1;
          busy_d     = 1'b1;
          idx_d      = idx_t'(Nk);
          kmod_d     = '0;
          rcon_idx_d = '0;
          fsm_d      = StExpand;
        end
      end
      StExpand: begin
        wr_word = 1'b1;
        idx_d   = idx_q + idx_t'(1);
        kmod_d  = (kmod_q == KmodW'(Nk - 1)) ? '0 : kmod_q + KmodW'(1);
        if (kmod_q == '0) rcon_idx_d = rcon_idx_q + 4'd1;
        if (idx_q == LastIdx) fsm_d = StArk0;
      end
      StArk0: begin
        rnd_d = RndW'(Nr - 1);
        fsm_d = StRound;
      end
      StRound: begin
        if (rnd_q == '0) begin
          out_d  = round_out;
          done_d = 1'b1;
          busy_d = 1'b0;
          fsm_d  = StIdle;
        end else begin
          rnd_d = rnd_q - RndW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= StIdle;
      idx_q      <= '0;
      rnd_q      <= '0;
      kmod_q     <= '0;
      rcon_idx_q <= '0;
      out_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      idx_q      <= idx_d;
      rnd_q      <= rnd_d;
      kmod_q     <= kmod_d;
      rcon_idx_q <= rcon_idx_d;
      out_q      <= out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Key schedule and round state carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (load) begin
      blk_q <= in;
      for (int j = 0; j < int'(Nk); j++) begin
        w_q[j] <= key[N-1-32*j -: 32];
      end
    end else if (fsm_q == StArk0) begin
      blk_q <= blk_q ^ round_key;
    end else if (fsm_q == StRound) begin
      blk_q <= round_out;
    end
    if (wr_word) w_q[idx_q] <= new_word;
  end

  assign out  = out_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
